// File: rtl/video_timing_rx_pkg.sv
// ============================================================================
//  video_timing_pkg
//  Shared FSM state encoding and the packed timing record for video_timing_rx.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package video_timing_pkg;

    // Field width of the timing record. It holds H_BITS/V_BITS values of up to 16 bits.
    localparam int MEAS_W = 16;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        MEAS = 2'd1,
        CHK  = 2'd2,
        LOCK = 2'd3
    } state_t;

    typedef struct packed {
        logic [MEAS_W-1:0] line_len;
        logic [MEAS_W-1:0] hs_width;
        logic [MEAS_W-1:0] hact_start;
        logic [MEAS_W-1:0] hact_width;
        logic [MEAS_W-1:0] frame_lines;
        logic [MEAS_W-1:0] vs_lines;
        logic [MEAS_W-1:0] vact_start;
        logic [MEAS_W-1:0] vact_lines;
    } timing_t;

endpackage

`default_nettype wire

// File: rtl/video_timing_rx_hmeas.sv
// ============================================================================
//  video_timing_hmeas
//  Per-line horizontal measurement with frame reference and consistency flag.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module video_timing_hmeas
    import video_timing_pkg::*;
#(
    parameter int H_BITS = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs_rise,
    input  logic              hs_lvl,
    input  logic              vld_lvl,
    input  logic              frame_end,
    output logic              line_active,
    output logic [H_BITS-1:0] line_len,
    output logic [H_BITS-1:0] hs_width,
    output logic [H_BITS-1:0] hact_start,
    output logic [H_BITS-1:0] hact_width,
    output logic              incons
);

    localparam logic [H_BITS-1:0] H_MAX = '1;

    logic [H_BITS-1:0] r_h_cnt;
    logic [H_BITS-1:0] r_hs_cnt;
    logic [H_BITS-1:0] r_vld_cnt;
    logic [H_BITS-1:0] r_vld_start;
    logic [H_BITS-1:0] r_prev_len;
    logic              r_line_vld;
    logic              r_prev_valid;
    logic              r_ref_valid;
    logic              r_incons;
    logic [H_BITS-1:0] r_ref_len;
    logic [H_BITS-1:0] r_ref_hsw;
    logic [H_BITS-1:0] r_ref_hst;
    logic [H_BITS-1:0] r_ref_hw;

    logic [H_BITS-1:0] w_len;
    logic [H_BITS-1:0] w_h_cnt;
    logic              w_ref_valid_n;
    logic              w_incons_n;
    logic [H_BITS-1:0] w_ref_len_n;
    logic [H_BITS-1:0] w_ref_hsw_n;
    logic [H_BITS-1:0] w_ref_hst_n;
    logic [H_BITS-1:0] w_ref_hw_n;

    // r_h_cnt holds last cycle's position, so the finished line length is r_h_cnt+1.
    assign w_len   = (r_h_cnt == H_MAX) ? H_MAX : r_h_cnt + 1'b1;
    assign w_h_cnt = hs_rise ? '0 : w_len;

    always_comb begin
        w_ref_valid_n = r_ref_valid;
        w_incons_n    = r_incons;
        w_ref_len_n   = r_ref_len;
        w_ref_hsw_n   = r_ref_hsw;
        w_ref_hst_n   = r_ref_hst;
        w_ref_hw_n    = r_ref_hw;
        if (hs_rise) begin
            if (r_line_vld) begin
                if (!r_ref_valid) begin
                    w_ref_valid_n = 1'b1;
                    w_ref_len_n   = w_len;
                    w_ref_hsw_n   = r_hs_cnt;
                    w_ref_hst_n   = r_vld_start;
                    w_ref_hw_n    = r_vld_cnt;
                end else if ({w_len, r_hs_cnt, r_vld_start, r_vld_cnt} !=
                             {r_ref_len, r_ref_hsw, r_ref_hst, r_ref_hw}) begin
                    w_incons_n = 1'b1;
                end
            end
            if (r_prev_valid && (w_len != r_prev_len)) begin
                w_incons_n = 1'b1;
            end
        end
        if (w_h_cnt == H_MAX) begin
            w_incons_n = 1'b1;
        end
    end

    // Frame view includes the line finishing this cycle, so frame end sees it.
    assign line_active = r_line_vld;
    assign line_len    = w_ref_len_n;
    assign hs_width    = w_ref_hsw_n;
    assign hact_start  = w_ref_hst_n;
    assign hact_width  = w_ref_hw_n;
    assign incons      = w_incons_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt      <= '0;
            r_hs_cnt     <= '0;
            r_vld_cnt    <= '0;
            r_vld_start  <= '0;
            r_prev_len   <= '0;
            r_line_vld   <= 1'b0;
            r_prev_valid <= 1'b0;
        end else if (hs_rise) begin
            r_h_cnt      <= '0;
            r_hs_cnt     <= {{(H_BITS-1){1'b0}}, hs_lvl};
            r_vld_cnt    <= {{(H_BITS-1){1'b0}}, vld_lvl};
            r_vld_start  <= '0;
            r_line_vld   <= vld_lvl;
            r_prev_len   <= w_len;
            r_prev_valid <= !frame_end;
        end else begin
            r_h_cnt <= w_h_cnt;
            if (hs_lvl && (r_hs_cnt != H_MAX)) begin
                r_hs_cnt <= r_hs_cnt + 1'b1;
            end
            if (vld_lvl) begin
                if (!r_line_vld) begin
                    r_vld_start <= w_h_cnt;
                    r_line_vld  <= 1'b1;
                end
                if (r_vld_cnt != H_MAX) begin
                    r_vld_cnt <= r_vld_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_valid <= 1'b0;
            r_incons    <= 1'b0;
            r_ref_len   <= '0;
            r_ref_hsw   <= '0;
            r_ref_hst   <= '0;
            r_ref_hw    <= '0;
        end else if (frame_end) begin
            r_ref_valid <= 1'b0;
            r_incons    <= 1'b0;
            r_ref_len   <= '0;
            r_ref_hsw   <= '0;
            r_ref_hst   <= '0;
            r_ref_hw    <= '0;
        end else begin
            r_ref_valid <= w_ref_valid_n;
            r_incons    <= w_incons_n;
            r_ref_len   <= w_ref_len_n;
            r_ref_hsw   <= w_ref_hsw_n;
            r_ref_hst   <= w_ref_hst_n;
            r_ref_hw    <= w_ref_hw_n;
        end
    end

endmodule

`default_nettype wire

// File: rtl/video_timing_rx.sv
// ============================================================================
//  video_timing_rx
//  Raster timing receiver: measures, checks stability, locks, sums pixels.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module video_timing_rx
    import video_timing_pkg::*;
#(
    parameter int PW     = 8,
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs,
    input  logic              vs,
    input  logic              vld,
    input  logic [3*PW-1:0]   rgb,
    output logic [H_BITS-1:0] line_len,
    output logic [H_BITS-1:0] hs_width,
    output logic [H_BITS-1:0] hact_start,
    output logic [H_BITS-1:0] hact_width,
    output logic [V_BITS-1:0] frame_lines,
    output logic [V_BITS-1:0] vs_lines,
    output logic [V_BITS-1:0] vact_start,
    output logic [V_BITS-1:0] vact_lines,
    output logic [3*PW-1:0]   frame_sum,
    output logic              meas_vld,
    output logic              locked,
    output logic              err
);

    localparam logic [V_BITS-1:0] V_MAX = '1;

    function automatic logic [V_BITS-1:0] v_inc(input logic [V_BITS-1:0] x);
        return (x == V_MAX) ? x : x + 1'b1;
    endfunction

    logic              r_hs;
    logic              r_vs;
    logic              r_vld;
    logic [3*PW-1:0]   r_rgb;
    logic              r_hs_prev;
    logic              r_vs_line;
    logic [V_BITS-1:0] r_v_cnt;
    logic [V_BITS-1:0] r_vs_lines;
    logic [V_BITS-1:0] r_vact_start;
    logic [V_BITS-1:0] r_vact_lines;
    logic              r_v_incons;
    logic [3*PW-1:0]   r_sum;
    timing_t           r_ref;
    state_t            r_state;

    logic              w_hs_rise;
    logic              w_frame_end;
    logic              w_line_active;
    logic [H_BITS-1:0] w_h_len;
    logic [H_BITS-1:0] w_h_hsw;
    logic [H_BITS-1:0] w_h_hst;
    logic [H_BITS-1:0] w_h_hw;
    logic              w_h_incons;
    logic [V_BITS-1:0] w_vs_lines_n;
    logic [V_BITS-1:0] w_vact_start_n;
    logic [V_BITS-1:0] w_vact_lines_n;
    logic              w_v_incons_n;
    logic              w_incons;
    logic              w_match;
    timing_t           w_cur;
    state_t            w_state_n;
    logic              w_meas_n;
    logic              w_err_n;
    logic              w_locked_n;
    logic              w_ref_load;
    logic              w_out_load;

    assign w_hs_rise   = r_hs & ~r_hs_prev;
    // Frame boundary is the line whose sampled vs level goes 0->1.
    assign w_frame_end = w_hs_rise & r_vs & ~r_vs_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_vld     <= 1'b0;
            r_rgb     <= '0;
            r_hs_prev <= 1'b0;
        end else begin
            r_hs      <= hs;
            r_vs      <= vs;
            r_vld     <= vld;
            r_rgb     <= rgb;
            r_hs_prev <= r_hs;
        end
    end

    video_timing_hmeas #(
        .H_BITS (H_BITS)
    ) u_hmeas (
        .clk         (clk),
        .rst         (rst),
        .hs_rise     (w_hs_rise),
        .hs_lvl      (r_hs),
        .vld_lvl     (r_vld),
        .frame_end   (w_frame_end),
        .line_active (w_line_active),
        .line_len    (w_h_len),
        .hs_width    (w_h_hsw),
        .hact_start  (w_h_hst),
        .hact_width  (w_h_hw),
        .incons      (w_h_incons)
    );

    always_comb begin
        w_vs_lines_n   = (w_hs_rise && r_vs_line) ? v_inc(r_vs_lines) : r_vs_lines;
        w_vact_start_n = r_vact_start;
        w_vact_lines_n = r_vact_lines;
        if (w_hs_rise && w_line_active) begin
            if (r_vact_lines == '0) begin
                w_vact_start_n = r_v_cnt;
            end
            w_vact_lines_n = v_inc(r_vact_lines);
        end
        w_v_incons_n = r_v_incons | (r_v_cnt == V_MAX);
    end

    always_comb begin
        w_cur             = '0;
        w_cur.line_len    = MEAS_W'(w_h_len);
        w_cur.hs_width    = MEAS_W'(w_h_hsw);
        w_cur.hact_start  = MEAS_W'(w_h_hst);
        w_cur.hact_width  = MEAS_W'(w_h_hw);
        w_cur.frame_lines = MEAS_W'(v_inc(r_v_cnt));
        w_cur.vs_lines    = MEAS_W'(w_vs_lines_n);
        w_cur.vact_start  = MEAS_W'(w_vact_start_n);
        w_cur.vact_lines  = MEAS_W'(w_vact_lines_n);
    end

    assign w_incons = w_h_incons | w_v_incons_n;
    assign w_match  = (w_cur == r_ref);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_line    <= 1'b0;
            r_v_cnt      <= '0;
            r_vs_lines   <= '0;
            r_vact_start <= '0;
            r_vact_lines <= '0;
            r_v_incons   <= 1'b0;
        end else begin
            r_v_incons <= w_frame_end ? 1'b0 : w_v_incons_n;
            if (w_hs_rise) begin
                r_vs_line <= r_vs;
                if (w_frame_end) begin
                    r_v_cnt      <= '0;
                    r_vs_lines   <= '0;
                    r_vact_start <= '0;
                    r_vact_lines <= '0;
                end else begin
                    r_v_cnt      <= v_inc(r_v_cnt);
                    r_vs_lines   <= w_vs_lines_n;
                    r_vact_start <= w_vact_start_n;
                    r_vact_lines <= w_vact_lines_n;
                end
            end
        end
    end

    // A pixel on the boundary cycle already belongs to the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (w_frame_end) begin
            r_sum <= r_vld ? r_rgb : '0;
        end else if (r_vld) begin
            r_sum <= r_sum + r_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEEK;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_meas_n   = 1'b0;
        w_err_n    = 1'b0;
        w_locked_n = locked;
        w_ref_load = 1'b0;
        w_out_load = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                SEEK: begin
                    w_state_n = MEAS;
                end
                MEAS: begin
                    w_state_n  = CHK;
                    w_ref_load = 1'b1;
                    w_meas_n   = 1'b1;
                    w_out_load = 1'b1;
                end
                CHK, LOCK: begin
                    w_meas_n   = 1'b1;
                    w_out_load = 1'b1;
                    if (w_match && !w_incons) begin
                        w_state_n  = LOCK;
                        w_locked_n = 1'b1;
                    end else begin
                        w_state_n  = CHK;
                        w_locked_n = 1'b0;
                        w_err_n    = 1'b1;
                        w_ref_load = 1'b1;
                    end
                end
                default: begin
                    w_state_n = SEEK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_vld    <= 1'b0;
            err         <= 1'b0;
            locked      <= 1'b0;
            r_ref       <= '0;
            line_len    <= '0;
            hs_width    <= '0;
            hact_start  <= '0;
            hact_width  <= '0;
            frame_lines <= '0;
            vs_lines    <= '0;
            vact_start  <= '0;
            vact_lines  <= '0;
            frame_sum   <= '0;
        end else begin
            meas_vld <= w_meas_n;
            err      <= w_err_n;
            locked   <= w_locked_n;
            if (w_ref_load) begin
                r_ref <= w_cur;
            end
            if (w_out_load) begin
                line_len    <= w_cur.line_len[H_BITS-1:0];
                hs_width    <= w_cur.hs_width[H_BITS-1:0];
                hact_start  <= w_cur.hact_start[H_BITS-1:0];
                hact_width  <= w_cur.hact_width[H_BITS-1:0];
                frame_lines <= w_cur.frame_lines[V_BITS-1:0];
                vs_lines    <= w_cur.vs_lines[V_BITS-1:0];
                vact_start  <= w_cur.vact_start[V_BITS-1:0];
                vact_lines  <= w_cur.vact_lines[V_BITS-1:0];
                frame_sum   <= r_sum;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_video_timing_rx.sv
// ============================================================================
//  tb_video_timing_rx
//  Directed raster stimulus for video_timing_rx with hand-computed results.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_video_timing_rx;

    logic        clk;
    logic        rst;
    logic        hs;
    logic        vs;
    logic        vld;
    logic [23:0] rgb;
    logic [11:0] line_len;
    logic [11:0] hs_width;
    logic [11:0] hact_start;
    logic [11:0] hact_width;
    logic [11:0] frame_lines;
    logic [11:0] vs_lines;
    logic [11:0] vact_start;
    logic [11:0] vact_lines;
    logic [23:0] frame_sum;
    logic        meas_vld;
    logic        locked;
    logic        err;

    typedef struct {
        logic [11:0] line_len;
        logic [11:0] hs_width;
        logic [11:0] hact_start;
        logic [11:0] hact_width;
        logic [11:0] frame_lines;
        logic [11:0] vs_lines;
        logic [11:0] vact_start;
        logic [11:0] vact_lines;
        logic [23:0] sum;
        logic        locked;
        logic        err;
    } meas_t;

    meas_t       meas_q[$];
    int          total    = 0;
    int          bad      = 0;
    int          err_seen = 0;
    logic [23:0] pix      = '0;

    video_timing_rx #(
        .PW     (8),
        .H_BITS (12),
        .V_BITS (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hs          (hs),
        .vs          (vs),
        .vld         (vld),
        .rgb         (rgb),
        .line_len    (line_len),
        .hs_width    (hs_width),
        .hact_start  (hact_start),
        .hact_width  (hact_width),
        .frame_lines (frame_lines),
        .vs_lines    (vs_lines),
        .vact_start  (vact_start),
        .vact_lines  (vact_lines),
        .frame_sum   (frame_sum),
        .meas_vld    (meas_vld),
        .locked      (locked),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (meas_vld) begin
            meas_q.push_back('{line_len, hs_width, hact_start, hact_width, frame_lines,
                               vs_lines, vact_start, vact_lines, frame_sum, locked, err});
        end
        if (err) begin
            err_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic h, input logic v, input logic d, input logic [23:0] c);
        @(negedge clk);
        hs  = h;
        vs  = v;
        vld = d;
        rgb = c;
    endtask

    // Frame starts on the first vs line; hs h=10..19, vld h=40..49 on lines 14..23.
    task automatic gen_lines(input int len, input int narrow_y, input int y0, input int y1);
        logic h_l;
        logic v_l;
        logic a_l;
        for (int y = y0; y < y1; y++) begin
            for (int x = 0; x < len; x++) begin
                if (y == 0 && x == 0) pix = '0;
                h_l = (x >= 10) && (x < 20);
                v_l = (y < 10);
                a_l = (y >= 14) && (y < 24) && (x >= 40) && (x < ((y == narrow_y) ? 49 : 50));
                tick(h_l, v_l, a_l, a_l ? pix : 24'hABCDEF);
                if (a_l) pix = pix + 24'd1;
            end
        end
    endtask

    task automatic chk_meas(input int i, input int lk, input int er, input int len,
                            input int hw, input int sum);
        chk($sformatf("meas%0d_count", i), meas_q.size(), i + 1);
        if (meas_q.size() > i) begin
            chk($sformatf("meas%0d_locked", i), meas_q[i].locked, lk);
            chk($sformatf("meas%0d_err", i), meas_q[i].err, er);
            chk($sformatf("meas%0d_line_len", i), meas_q[i].line_len, len);
            chk($sformatf("meas%0d_hact_width", i), meas_q[i].hact_width, hw);
            chk($sformatf("meas%0d_frame_sum", i), meas_q[i].sum, sum);
        end
    endtask

    initial begin
        rst = 1'b1;
        hs  = 1'b0;
        vs  = 1'b0;
        vld = 1'b0;
        rgb = '0;
        repeat (3) @(negedge clk);
        chk("rst_line_len", line_len, 0);
        chk("rst_frame_lines", frame_lines, 0);
        chk("rst_frame_sum", frame_sum, 0);
        chk("rst_meas_vld", meas_vld, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        gen_lines(61, -1, 0, 41);
        gen_lines(61, -1, 0, 41);
        chk_meas(0, 0, 0, 61, 10, 24'h001356);
        if (meas_q.size() > 0) begin
            chk("meas0_hs_width", meas_q[0].hs_width, 10);
            chk("meas0_hact_start", meas_q[0].hact_start, 30);
            chk("meas0_frame_lines", meas_q[0].frame_lines, 41);
            chk("meas0_vs_lines", meas_q[0].vs_lines, 10);
            chk("meas0_vact_start", meas_q[0].vact_start, 14);
            chk("meas0_vact_lines", meas_q[0].vact_lines, 10);
        end

        gen_lines(61, -1, 0, 41);
        chk_meas(1, 1, 0, 61, 10, 24'h001356);

        gen_lines(62, -1, 0, 41);
        chk_meas(2, 1, 0, 61, 10, 24'h001356);

        gen_lines(61, -1, 0, 41);
        chk_meas(3, 0, 1, 62, 10, 24'h001356);

        gen_lines(61, -1, 0, 41);
        chk_meas(4, 0, 1, 61, 10, 24'h001356);

        gen_lines(61, 18, 0, 41);
        chk_meas(5, 1, 0, 61, 10, 24'h001356);

        gen_lines(61, -1, 0, 41);
        chk_meas(6, 0, 1, 61, 10, 24'h0012F3);

        gen_lines(61, -1, 0, 25);
        chk_meas(7, 1, 0, 61, 10, 24'h001356);
        chk("pre_rst_locked", locked, 1);

        #2 rst = 1'b1;
        #1;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_line_len", line_len, 0);
        chk("mid_rst_frame_lines", frame_lines, 0);
        chk("mid_rst_frame_sum", frame_sum, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        gen_lines(61, -1, 25, 41);
        gen_lines(61, -1, 0, 41);
        chk("post_rst_one_end_count", meas_q.size(), 8);
        gen_lines(61, -1, 0, 41);
        chk_meas(8, 0, 0, 61, 10, 24'h001356);
        gen_lines(61, -1, 0, 41);
        chk_meas(9, 1, 0, 61, 10, 24'h001356);

        repeat (5000) tick(1'b0, 1'b0, 1'b0, 24'h0);
        chk("no_hs_h_cnt_sat", dut.u_hmeas.r_h_cnt, 12'hFFF);
        chk("no_hs_locked", locked, 1);
        chk("no_hs_meas_count", meas_q.size(), 10);
        chk("err_pulse_total", err_seen, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/video_timing_rx.md
Name: video_timing_rx

Overview:
- Receive-side counterpart of the test pattern generator: consumes an hs/vs/vld/rgb raster stream and measures its horizontal and vertical timing.
- Checks that the timing is stable frame-to-frame, asserts lock once it is, and reports a per-frame additive pixel checksum.
- Sits at a video input port or a bench loopback, directly downstream of the generator, in the same clock domain.

Parameters:
PW, 8, bits per colour component (rgb is 3*PW)
H_BITS, 12, width of horizontal counters/results
V_BITS, 12, width of vertical counters/results

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
hs  in  1  horizontal sync, active-high
vs  in  1  vertical sync, active-high
vld  in  1  active-pixel qualifier
rgb  in  3*PW  pixel data, valid when vld=1
line_len  out  H_BITS  clocks from one hs rise to the next
hs_width  out  H_BITS  clocks hs high per line
hact_start  out  H_BITS  h_cnt at first vld=1 of a line (h_cnt=0 on hs-rise cycle)
hact_width  out  H_BITS  vld=1 clocks per active line
frame_lines  out  V_BITS  lines per frame
vs_lines  out  V_BITS  lines with vs=1
vact_start  out  V_BITS  v_cnt of first line containing vld
vact_lines  out  V_BITS  lines containing vld
frame_sum  out  3*PW  modulo-2^(3*PW) sum of rgb over vld cycles of the frame
meas_vld  out  1  1-cycle pulse: all results above updated
locked  out  1  timing stable
err  out  1  1-cycle pulse: mismatch, intra-frame inconsistency or counter saturation

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM in SEEK; counters 0.
- Inputs registered once; an edge is detected as registered=1 with previous=0.
- h_cnt:
  - 0 on the hs-rise cycle, +1 otherwise; saturates at all-ones.
  - On hs rise, line_len_cur = h_cnt+1 of the finished line.
  - hs_width counts hs=1 clocks in the line.
  - hact_start = h_cnt on the first vld=1 cycle of the line; hact_width counts vld=1 clocks.
- Vertical bookkeeping happens only on hs-rise cycles, using the registered vs level:
  - v_cnt=0 on the line where vs goes 0->1 (line-sampled), +1 otherwise; saturates.
  - frame_lines = v_cnt+1 at the next vs rise.
  - vs_lines counts lines with vs=1.
  - vact_start/vact_lines are based on lines that contained any vld.
- Intra-frame consistency:
  - The horizontal tuple (line_len, hs_width, hact_start, hact_width) of the first active line is the frame reference.
  - Any later active line that differs sets the frame's incons flag.
  - line_len is checked on every line.
- Counter saturation sets incons.
- Frame end (line-sampled vs rise):
  - Latch all results and frame_sum to the outputs.
  - Pulse meas_vld one cycle later.
  - Clear accumulators; the sum restarts at 0.
- FSM:
  - SEEK --first frame end--> MEAS (first frame is partial, its results are discarded, no meas_vld).
  - MEAS --frame end--> CHK: store frame as ref; meas_vld pulses.
  - CHK --frame end, equal to ref and no incons--> LOCK: locked=1 in the meas_vld cycle.
  - CHK --frame end, differs or incons--> CHK: ref reloaded; err pulse.
  - LOCK --frame end, differs or incons--> CHK: locked=0 and err pulse in the meas_vld cycle.
  - LOCK --equal--> LOCK.
- frame_sum is excluded from the equality check, since pattern content may change.
- hs/vs absent: counters saturate, raising incons; no frame end occurs, so locked holds. A watchdog is not required.
- Simultaneous hs rise and vs rise on the same line: that line is v_cnt=0 of the new frame.
- vld outside active lines is still counted.
- Reset mid-frame: immediate return to SEEK; locked=0.

Decomposition:
- Package video_timing_pkg: FSM state enum (SEEK, MEAS, CHK, LOCK) and a packed struct timing_t holding the 8 measurements, so ref compare is a single equality.
- One sub-module, video_timing_hmeas: per-line horizontal measurement and intra-frame consistency. The top holds the vertical counters, FSM and checksum.

Test Plan:
- Raster with line 61 clocks, hs at h=10..19, vld at h=40..49, 41 lines/frame, vs lines 11..20, vld lines 25..34 -> first meas_vld: line_len=61, hs_width=10, hact_start=30, hact_width=10, frame_lines=41, vs_lines=10, vact_start=14, vact_lines=10. locked=1 at the second meas_vld; err never pulses.
- Same raster, rgb = pixel index 0..99 per frame -> frame_sum=0x001356 (4950) every frame (PW=8).
- After lock, one frame with line_len 62 -> err pulse and locked=0 at that frame's meas_vld; relock at the second good frame after it.
- One active line with vld 9 clocks wide mid-frame -> incons; err at frame end; no lock that frame.
- rst pulse mid-frame while locked -> all outputs 0 asynchronously; first meas_vld returns after 2 frame ends.
- hs held low 5000 clocks -> h_cnt saturates at 0xFFF; locked unchanged; no meas_vld.
